// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer
//   Pulls 24-bit GRB pixels from a pixel store and feeds them one bit at a
//   time, MSB first, to a WS2811 PWM bit encoder. After the frame it holds
//   the line low for LATCH_CYCLES, then pulses done. One pixel is
//   prefetched so that consecutive pixels go out back-to-back. If that
//   prefetch is not ready in time, the frame is aborted and underrun is set.
//
// Ports
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   start, num_leds      one-cycle frame request and LED count (taken in IDLE)
//   pix_req, pix_addr    pixel fetch request (held until acked) and LED index
//   pix_data, pix_valid  GRB pixel and its one-cycle acknowledge
//   bit_data, bit_valid  bit to the encoder and its one-cycle load strobe
//   bit_select           encoder run enable for the whole bit stream
//   bit_top              encoder ready-for-next-bit level
//   busy, done           frame in progress / one-cycle end-of-latch pulse
//   underrun             sticky error, cleared by the next accepted start
module ws2811_frame_sequencer #(
    parameter int N_W          = 8,
    parameter int LATCH_CYCLES = 2600
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] num_leds,
    output logic           pix_req,
    output logic [N_W-1:0] pix_addr,
    input  logic [23:0]    pix_data,
    input  logic           pix_valid,
    output logic           bit_data,
    output logic           bit_valid,
    output logic           bit_select,
    input  logic           bit_top,
    output logic           busy,
    output logic           done,
    output logic           underrun
);

    localparam int LC_W = $clog2(LATCH_CYCLES + 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [N_W-1:0]  index_q, index_d;
    logic [N_W-1:0]  nleds_q, nleds_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bitcnt_q, bitcnt_d;
    logic [23:0]     pre_q, pre_d;
    logic            pre_full_q, pre_full_d;
    logic            exh_q, exh_d;          // current pixel fully sent, next one not yet moved in
    logic            first_q, first_d;      // first cycle of SEND: issue without waiting for bit_top
    logic            bv_prev_q, bv_prev_d;
    logic            top_wait_q, top_wait_d;
    logic [LC_W-1:0] lcnt_q, lcnt_d;
    logic            underrun_q, underrun_d;
    logic            slot;

    assign busy     = (state_q != S_IDLE);
    assign pix_addr = index_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        nleds_d    = nleds_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        pre_d      = pre_q;
        pre_full_d = pre_full_q;
        exh_d      = exh_q;
        first_d    = 1'b0;
        top_wait_d = top_wait_q;
        lcnt_d     = lcnt_q;
        underrun_d = underrun_q;
        pix_req    = 1'b0;
        bit_data   = 1'b0;
        bit_valid  = 1'b0;
        bit_select = 1'b0;
        done       = 1'b0;
        slot       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    nleds_d    = num_leds;
                    index_d    = '0;
                    pre_full_d = 1'b0;
                    exh_d      = 1'b0;
                    top_wait_d = 1'b0;
                    lcnt_d     = '0;
                    state_d    = (num_leds != '0) ? S_FETCH : S_LATCH;
                end
            end

            S_FETCH: begin
                pix_req = 1'b1;
                if (pix_valid) begin
                    shift_d  = pix_data;
                    bitcnt_d = 5'd23;
                    index_d  = index_q + N_W'(1);
                    first_d  = 1'b1;
                    state_d  = S_SEND;
                end
            end

            S_SEND: begin
                bit_select = 1'b1;
                bit_data   = exh_q ? pre_q[23] : shift_q[23];
                // bv_prev_q masks the cycle where bit_top has not yet dropped
                // in response to the strobe just issued.
                slot       = first_q | (bit_top & ~bv_prev_q);
                if (slot && exh_q && !pre_full_q) begin
                    underrun_d = 1'b1;
                    bit_select = 1'b0;
                    top_wait_d = 1'b1;
                    lcnt_d     = '0;
                    state_d    = S_LATCH;
                end else begin
                    pix_req = (index_q < nleds_q) && !pre_full_q;
                    if (pix_req && pix_valid) begin
                        pre_d      = pix_data;
                        pre_full_d = 1'b1;
                        index_d    = index_q + N_W'(1);
                    end
                    if (slot) begin
                        bit_valid = 1'b1;
                        if (exh_q) begin
                            shift_d    = {pre_q[22:0], 1'b0};
                            bitcnt_d   = 5'd22;
                            pre_full_d = 1'b0;
                            exh_d      = 1'b0;
                        end else if (bitcnt_q != 5'd0) begin
                            shift_d  = {shift_q[22:0], 1'b0};
                            bitcnt_d = bitcnt_q - 5'd1;
                        end else if (pre_full_q) begin
                            // Move the prefetched pixel in now so the prefetch
                            // slot frees up for the following LED.
                            shift_d    = pre_q;
                            bitcnt_d   = 5'd23;
                            pre_full_d = 1'b0;
                        end else if (index_q == nleds_q) begin
                            bit_select = 1'b0;
                            top_wait_d = 1'b1;
                            lcnt_d     = '0;
                            state_d    = S_LATCH;
                        end else begin
                            exh_d = 1'b1;
                        end
                    end
                end
            end

            S_LATCH: begin
                if (top_wait_q) begin
                    if (bit_top) top_wait_d = 1'b0;
                end else if (lcnt_q == LC_LAST) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lcnt_d = lcnt_q + LC_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        bv_prev_d = bit_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            nleds_q    <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            pre_q      <= '0;
            pre_full_q <= 1'b0;
            exh_q      <= 1'b0;
            first_q    <= 1'b0;
            bv_prev_q  <= 1'b0;
            top_wait_q <= 1'b0;
            lcnt_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            nleds_q    <= nleds_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            pre_q      <= pre_d;
            pre_full_q <= pre_full_d;
            exh_q      <= exh_d;
            first_q    <= first_d;
            bv_prev_q  <= bv_prev_d;
            top_wait_q <= top_wait_d;
            lcnt_q     <= lcnt_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Testbench for ws2811_frame_sequencer: behavioural 125-cycle bit encoder,
// pixel store with per-address response delay, negedge monitor, and one
// task per scenario with inline comparisons.
module tb_ws2811_frame_sequencer;

    localparam int PERIOD = 125;
    localparam int LATCH  = 2600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_leds;
    logic        pix_req;
    logic [7:0]  pix_addr;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        bit_data;
    logic        bit_valid;
    logic        bit_select;
    logic        bit_top;
    logic        busy;
    logic        done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ws2811_frame_sequencer #(.N_W(8), .LATCH_CYCLES(LATCH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_leds(num_leds),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data),
        .pix_valid(pix_valid), .bit_data(bit_data), .bit_valid(bit_valid),
        .bit_select(bit_select), .bit_top(bit_top), .busy(busy),
        .done(done), .underrun(underrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: bit_top drops after a strobe, rises PERIOD cycles later.
    int per_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_top <= 1'b1;
            per_cnt <= 0;
        end else if (bit_valid) begin
            bit_top <= 1'b0;
            per_cnt <= PERIOD - 1;
        end else if (!bit_top) begin
            if (per_cnt == 1) bit_top <= 1'b1;
            per_cnt <= per_cnt - 1;
        end
    end

    // Pixel store: answers dly[addr] cycles after pix_req is seen.
    logic [23:0] tbl [8];
    int          dly [8];
    int          wcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            wcnt      <= 0;
        end else begin
            pix_valid <= 1'b0;
            if (pix_valid || !pix_req) begin
                wcnt <= 0;
            end else if (wcnt >= dly[pix_addr[2:0]] - 1) begin
                pix_valid <= 1'b1;
                pix_data  <= tbl[pix_addr[2:0]];
                wcnt      <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Monitor
    bit   bits [$];
    int   bv_cyc [$];
    int   addrs [$];
    int   sel_hi, last_sel, done_cnt, done_cyc, last_top_rise;
    int   req_cycles, busy_cycles, ur_rise, sel_at_ur, req_at_ur;
    logic top_prev = 1'b0;
    logic ur_prev  = 1'b0;

    always @(negedge clk) begin
        if (bit_valid) begin
            bits.push_back(bit_data);
            bv_cyc.push_back(cyc);
            last_sel = int'(bit_select);
            if (bit_select) sel_hi++;
        end
        if (bit_top && !top_prev) last_top_rise = cyc;
        top_prev = bit_top;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pix_req) req_cycles++;
        if (pix_req && pix_valid) addrs.push_back(int'(pix_addr));
        if (busy) busy_cycles++;
        if (underrun && !ur_prev) begin
            ur_rise   = cyc;
            sel_at_ur = int'(bit_select);
            req_at_ur = int'(pix_req);
        end
        ur_prev = underrun;
    end

    task automatic clear_mon();
        bits.delete();
        bv_cyc.delete();
        addrs.delete();
        sel_hi = 0; last_sel = -1; done_cnt = 0; done_cyc = -1;
        last_top_rise = -1; req_cycles = 0; busy_cycles = 0;
        ur_rise = -1; sel_at_ur = -1; req_at_ur = -1;
    endtask

    function automatic logic [71:0] packbits();
        logic [71:0] v = '0;
        for (int i = 0; i < bits.size(); i++) v = {v[70:0], bits[i]};
        return v;
    endfunction

    task automatic start_frame(input logic [7:0] n);
        @(negedge clk);
        start    = 1'b1;
        num_leds = n;
        @(negedge clk);
        start    = 1'b0;
        num_leds = 8'hEE;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        wait_cycles(1);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, expected one pulse", name, budget);
        end
    endtask

    task automatic wait_bits(input int nb, input int budget, input string name);
        int n = 0;
        while (bits.size() < nb && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bits.size() < nb) begin
            errors++;
            $display("FAIL %s_bit_timeout: %0d bits seen, expected at least %0d", name, bits.size(), nb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_leds = '0;
        for (int i = 0; i < 8; i++) begin
            tbl[i] = 24'h000000;
            dly[i] = 2;
        end
        clear_mon();
        wait_cycles(3);
        checks++;
        if ({pix_req, bit_data, bit_valid, bit_select, busy, done, underrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", {pix_req, bit_data, bit_valid, bit_select, busy, done, underrun});
        end
        checks++;
        if (pix_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_pix_addr: got %0h expected 0", pix_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_pixel();
        logic [71:0] g;
        tbl[0] = 24'hA50FF0;
        clear_mon();
        start_frame(8'd1);
        wait_done(10000, "single");
        g = packbits();
        checks++;
        if (bits.size() != 24) begin
            errors++; $display("FAIL single_bit_count: got %0d expected 24", bits.size());
        end
        checks++;
        if (g[23:0] !== 24'hA50FF0) begin
            errors++; $display("FAIL single_bit_data: got %h expected a50ff0", g[23:0]);
        end
        checks++;
        if (sel_hi != 23 || last_sel != 0) begin
            errors++; $display("FAIL single_select: sel_hi %0d last_sel %0d expected 23 and 0", sel_hi, last_sel);
        end
        checks++;
        if (done_cyc - last_top_rise != LATCH) begin
            errors++; $display("FAIL single_latch_len: got %0d expected %0d", done_cyc - last_top_rise, LATCH);
        end
        checks++;
        if (bv_cyc.size() == 24 && done_cyc - bv_cyc[23] != PERIOD + LATCH) begin
            errors++; $display("FAIL single_done_time: got %0d expected %0d", done_cyc - bv_cyc[23], PERIOD + LATCH);
        end
        checks++;
        if (addrs.size() != 1 || underrun !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_misc: fetches %0d underrun %b busy %b expected 1 0 0", addrs.size(), underrun, busy);
        end
    endtask

    task automatic test_three_pixels();
        logic [71:0] g;
        int bad = 0;
        tbl[0] = 24'h123456; tbl[1] = 24'hFEDCBA; tbl[2] = 24'h00FF81;
        clear_mon();
        start_frame(8'd3);
        wait_done(20000, "three");
        g = packbits();
        checks++;
        if (bits.size() != 72) begin
            errors++; $display("FAIL three_bit_count: got %0d expected 72", bits.size());
        end
        checks++;
        if (g !== {24'h123456, 24'hFEDCBA, 24'h00FF81}) begin
            errors++; $display("FAIL three_bit_data: got %h expected 123456fedcba00ff81", g);
        end
        for (int i = 1; i < bv_cyc.size(); i++)
            if (bv_cyc[i] - bv_cyc[i-1] != PERIOD) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL three_spacing: %0d gaps differ from %0d cycles, expected 0", bad, PERIOD);
        end
        checks++;
        if (addrs.size() != 3 || addrs[0] != 0 || addrs[1] != 1 || addrs[2] != 2) begin
            errors++; $display("FAIL three_addrs: got %0d fetches (%0d,%0d,%0d) expected 0,1,2", addrs.size(), addrs[0], addrs[1], addrs[2]);
        end
        checks++;
        if (underrun !== 1'b0 || sel_hi != 71) begin
            errors++; $display("FAIL three_underrun_sel: underrun %b sel_hi %0d expected 0 and 71", underrun, sel_hi);
        end
    endtask

    task automatic test_underrun();
        logic [71:0] g;
        tbl[0] = 24'hC0FFEE; tbl[1] = 24'h111111;
        dly[1] = 4000;
        clear_mon();
        start_frame(8'd2);
        wait_done(12000, "underrun");
        dly[1] = 2;
        g = packbits();
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_flag: got %b expected 1", underrun);
        end
        checks++;
        if (bits.size() != 24 || g[23:0] !== 24'hC0FFEE) begin
            errors++; $display("FAIL underrun_bits: got %0d bits %h expected 24 bits c0ffee", bits.size(), g[23:0]);
        end
        checks++;
        if (bv_cyc.size() == 24 && ur_rise != bv_cyc[23] + PERIOD + 1) begin
            errors++; $display("FAIL underrun_time: got %0d expected %0d", ur_rise, bv_cyc[23] + PERIOD + 1);
        end
        checks++;
        if (sel_at_ur != 0 || req_at_ur != 0 || done_cnt != 1) begin
            errors++; $display("FAIL underrun_stop: sel %0d req %0d done %0d expected 0 0 1", sel_at_ur, req_at_ur, done_cnt);
        end
    endtask

    task automatic test_zero_leds();
        clear_mon();
        start_frame(8'd0);
        wait_done(5000, "zero");
        checks++;
        if (req_cycles != 0 || bits.size() != 0) begin
            errors++; $display("FAIL zero_activity: req cycles %0d bits %0d expected 0 0", req_cycles, bits.size());
        end
        checks++;
        if (busy_cycles != LATCH) begin
            errors++; $display("FAIL zero_busy_len: got %0d expected %0d", busy_cycles, LATCH);
        end
        checks++;
        if (done_cnt != 1 || underrun !== 1'b0) begin
            errors++; $display("FAIL zero_done_underrun: done %0d underrun %b expected 1 0", done_cnt, underrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [71:0] g;
        tbl[0] = 24'hFFFFFF; tbl[1] = 24'hFFFFFF; tbl[2] = 24'h0; tbl[3] = 24'h0;
        clear_mon();
        start_frame(8'd4);
        wait_bits(10, 5000, "midreset");
        wait_cycles(20);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_req, pix_addr, bit_data, bit_valid, bit_select, busy, done, underrun} !== 15'b0) begin
            errors++; $display("FAIL midreset_outputs: got %b expected all 0", {pix_req, pix_addr, bit_data, bit_valid, bit_select, busy, done, underrun});
        end
        wait_cycles(5);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(3000);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_done: done %0d busy %b expected 0 0", done_cnt, busy);
        end
        tbl[0] = 24'h3CC35A;
        clear_mon();
        start_frame(8'd1);
        wait_done(10000, "postreset");
        g = packbits();
        checks++;
        if (bits.size() != 24 || g[23:0] !== 24'h3CC35A || done_cnt != 1) begin
            errors++; $display("FAIL postreset_frame: %0d bits %h done %0d expected 24 bits 3cc35a done 1", bits.size(), g[23:0], done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        logic [71:0] g;
        tbl[0] = 24'h5A5A5A; tbl[1] = 24'h0F0F0F;
        clear_mon();
        start_frame(8'd2);
        wait_bits(5, 2000, "ignore_send");
        start_frame(8'd7);
        wait_bits(48, 8000, "ignore_all");
        wait_cycles(300);
        start_frame(8'd3);
        wait_done(6000, "ignore");
        wait_cycles(3000);
        g = packbits();
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_done_count: done %0d busy %b expected 1 0", done_cnt, busy);
        end
        checks++;
        if (bits.size() != 48 || g[47:0] !== {24'h5A5A5A, 24'h0F0F0F}) begin
            errors++; $display("FAIL ignore_bits: %0d bits %h expected 48 bits 5a5a5a0f0f0f", bits.size(), g[47:0]);
        end
        checks++;
        if (addrs.size() != 2) begin
            errors++; $display("FAIL ignore_fetches: got %0d expected 2", addrs.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_underrun();
        test_zero_leds();
        test_reset_mid_frame();
        test_ignored_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
